rr_grant_arbiter: RTL and testbench
===================================

Name: rr_grant_arbiter

Overview:
- Four-requester arbiter for one shared resource; the resource is driven by a one-hot line decoder.
- Accepts requests on the tile input pins and chooses one owner, round-robin or fixed priority.
- Drives a one-hot grant plus its binary index, so the downstream 2-to-4 decode logic consumes either form directly.
- Enforces a bounded hold time.
- Inserts a one-cycle dead slot between owners so two grant lines are never high together.

Parameters:
- TIMEOUT, 15: maximum consecutive cycles one owner holds the grant (legal range 2..255).
- CNT_W, 8: hold-counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- io_in[0], input, 1: clock; every flop is rising-edge on this clock.
- io_in[1], input, 1: reset; synchronous, active-high.
- io_in[5:2], input, 4: req[3:0]; level requests, bit k = requester k.
- io_in[6], input, 1: done; the current owner releases the grant.
- io_in[7], input, 1: prio_mode; 0 = round-robin, 1 = fixed priority (req0 highest).
- io_out[3:0], output, 4: gnt[3:0]; one-hot grant, or all zero.
- io_out[5:4], output, 2: gnt_idx; binary index of the owner (holds its last value when no grant is active).
- io_out[6], output, 1: gnt_valid; high exactly when gnt != 0.
- io_out[7], output, 1: tout; one-cycle pulse, high during the RELEASE cycle that follows a timeout.

Behaviour:
- Interface: single top module; io_in[7:0] in, io_out[7:0] out. Clock is io_in[0]. Reset is io_in[1], synchronous and active-high.
- All outputs are registered; no combinational path from pins to outputs.
- Reset (at a rising edge with rst=1):
  - state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, tout=0, rr_ptr=0, cnt=0.
  - Reset wins over every other event, including mid-grant: grant is dropped at that edge with no RELEASE slot.
- States: IDLE, GRANT, RELEASE (2-bit encoding).
- IDLE:
  - If req != 0 at an edge, pick winner w, move to GRANT, load gnt=1<<w, gnt_idx=w, gnt_valid=1, cnt=0.
  - Latency: a request sampled at edge n is visible on gnt after edge n.
  - Winner selection:
    - prio_mode=0: first set bit of req scanning rr_ptr, rr_ptr+1, ... mod 4.
    - prio_mode=1: lowest set index.
  - prio_mode is sampled only in IDLE; changing it mid-grant has no effect on the current grant.
- GRANT:
  - cnt increments every cycle, saturating.
  - Release conditions, checked each edge, any of: done=1; req[owner]=0; cnt==TIMEOUT-1.
  - On release: move to RELEASE, clear gnt and gnt_valid, set rr_ptr=(owner+1) mod 4. rr_ptr advances in both priority modes.
  - tout is set to 1 in RELEASE only when the release came from timeout and done=0 and req[owner]=1.
  - done and timeout in the same cycle: done wins, tout stays 0.
  - Maximum hold is exactly TIMEOUT cycles of gnt high.
  - req changes for non-owners are ignored during GRANT.
- RELEASE:
  - Exactly one cycle with gnt=0; tout is as set on entry.
  - Next edge: return to IDLE, tout=0.
  - Minimum spacing between two grants is therefore two clock edges (RELEASE then IDLE arbitration); IDLE takes at least one cycle.
- Invariants:
  - gnt is zero or one-hot at all times.
  - gnt_valid == |gnt.
  - When gnt_valid=1, gnt == 1<<gnt_idx.
- Boundaries:
  - Owner requests again immediately after release: in round-robin it wins only if no other req is set; in fixed priority, req0 can starve others (documented, intended).
  - Wrap-around: rr_ptr=3 with owner 3 released gives rr_ptr=0.
  - done asserted in IDLE or RELEASE is ignored.

Decomposition:
- Shared package arb_pkg holds:
  - state enum IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2;
  - N_REQ=4;
  - IDX_W=2;
  - default TIMEOUT.
- One combinational sub-module, arb4_pick: inputs req[3:0], ptr[1:0], fixed; outputs win_idx[1:0], any.
  - Implemented as rotate, priority-encode, un-rotate.
  - Instantiated once by the FSM.

Test Plan:
1. Reset with req=4'b1111, then release reset, prio_mode=0, hold all requests with done pulses → grant order idx 0,1,2,3,0; each grant separated by gnt=0 in RELEASE and IDLE; gnt_valid tracks gnt.
2. req=4'b0100 held, done=0, TIMEOUT=15 → gnt=4'b0100 for exactly 15 cycles; tout=1 for one cycle while gnt=0; re-grant to idx 2 after IDLE.
3. prio_mode=1, req=4'b1010 held, done pulsed each grant → grants alternate only to idx 1 (never idx 3); rr_ptr still advances to 2.
4. Owner 1 active, done=1 on the same edge where cnt==TIMEOUT-1 → release with tout=0.
5. Reset asserted mid-grant (owner 2, cnt=5) → next edge all outputs 0; state IDLE; after reset deassert with req=4'b0100, grant to idx 2 after one edge (rr_ptr=0).
6. Owner 0 granted, req changes from 4'b0001 to 4'b0011 then req[0] drops → release; RELEASE cycle; grant to idx 1; gnt never shows two bits set.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared types and constants for the four-requester grant arbiter.
package arb_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;
    localparam int N_REQ       = 4;
    localparam int IDX_W       = 2;
    localparam int TIMEOUT_DEF = 15;
endpackage

// File: rtl/arb4_pick.sv
// arb4_pick: rotate-from-pointer priority pick over four requests.
module arb4_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic             fixed_i,
    output logic [IDX_W-1:0] win_idx_o,
    output logic             any_o
);
    logic [IDX_W-1:0] sh;
    logic [IDX_W-1:0] enc;
    logic [N_REQ-1:0] rot;
    always_comb begin
        sh = fixed_i ? '0 : ptr_i;
        for (int k = 0; k < N_REQ; k++) rot[k] = req_i[IDX_W'(k + int'(sh))];
        enc = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        win_idx_o = enc + sh;
        any_o = |req_i;
    end
endmodule

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin / fixed-priority grant with bounded hold and
// a one-cycle dead slot between owners; all outputs registered.
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 8
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);
    logic             clk;
    logic             rst;
    logic             done;
    logic             prio_mode;
    logic [N_REQ-1:0] req;
    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             vld_q, vld_d;
    logic             tout_q, tout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] win_idx;
    logic             any;
    logic             hit_to;
    logic             rel;

    assign clk       = io_in[0];
    assign rst       = io_in[1];
    assign req       = io_in[5:2];
    assign done      = io_in[6];
    assign prio_mode = io_in[7];

    arb4_pick u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .fixed_i  (prio_mode),
        .win_idx_o(win_idx),
        .any_o    (any)
    );

    assign hit_to = cnt_q == CNT_W'(TIMEOUT - 1);
    assign rel    = done || !req[idx_q] || hit_to;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            vld_q   <= 1'b0;
            tout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            vld_q   <= vld_d;
            tout_q  <= tout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        vld_d   = vld_q;
        tout_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (any) begin
                state_d = GRANT;
                gnt_d   = N_REQ'(1) << win_idx;
                idx_d   = win_idx;
                vld_d   = 1'b1;
                cnt_d   = '0;
            end
            GRANT: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                if (rel) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                    vld_d   = 1'b0;
                    ptr_d   = idx_q + 1'b1;
                    // tout flags only a pure timeout: done or a dropped request take precedence
                    tout_d  = hit_to && !done && req[idx_q];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign io_out = {tout_q, vld_q, idx_q, gnt_q};
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter: scenario tasks plus random traffic against a
// cycle-level reference model of the arbitration rules.
module tb_rr_grant_arbiter;
    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       done = 1'b0;
    logic       prio = 1'b0;
    logic [3:0] req = 4'b0;
    logic [7:0] io_in;
    logic [7:0] io_out;
    int total = 0;
    int bad = 0;

    int   m_state = 0;
    int   m_idx = 0;
    int   m_ptr = 0;
    int   m_held = 0;
    logic m_tout = 1'b0;

    assign io_in = {prio, done, req, rst, clk};

    rr_grant_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    always #5 clk = ~clk;

    function automatic void model_update();
        int  c;
        bit  found;
        if (rst) begin
            m_state = 0; m_idx = 0; m_ptr = 0; m_held = 0; m_tout = 1'b0;
        end else if (m_state == 0) begin
            m_tout = 1'b0;
            found = 0;
            for (int k = 0; k < 4; k++) begin
                c = prio ? k : (m_ptr + k) % 4;
                if (!found && req[c]) begin
                    found = 1;
                    m_idx = c;
                end
            end
            if (found) begin
                m_state = 1;
                m_held = 1;
            end
        end else if (m_state == 1) begin
            if (done || !req[m_idx] || m_held == TO) begin
                m_tout = (m_held == TO) && !done && req[m_idx];
                m_ptr = (m_idx + 1) % 4;
                m_state = 2;
            end else begin
                m_held++;
            end
        end else begin
            m_state = 0;
            m_tout = 1'b0;
        end
    endfunction

    function automatic logic [7:0] exp_out();
        logic [3:0] g;
        g = (m_state == 1) ? 4'(1 << m_idx) : 4'b0;
        return {m_tout, m_state == 1, 2'(m_idx), g};
    endfunction

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; done = 1'b1; prio = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (io_out !== 8'h00) begin
                bad++;
                $display("FAIL reset_out: got %h want 00", io_out);
            end
        end
        rst = 1'b0; done = 1'b0;
    endtask

    task automatic test_rr_order();
        int  order[5];
        int  n = 0;
        bit  prevv = 0;
        for (int i = 0; i < 40 && n < 5; i++) begin
            step();
            total++;
            if (io_out !== exp_out()) begin
                bad++;
                $display("FAIL rr_model: got %h want %h", io_out, exp_out());
            end
            done = 1'b0;
            if (io_out[6] && !prevv) begin
                order[n] = int'(io_out[5:4]);
                n++;
                done = 1'b1;
            end
            prevv = io_out[6];
        end
        done = 1'b0;
        total++;
        if (n != 5) begin
            bad++;
            $display("FAIL rr_count: got %0d want 5", n);
        end
        for (int k = 0; k < n; k++) begin
            total++;
            if (order[k] != k % 4) begin
                bad++;
                $display("FAIL rr_order[%0d]: got %0d want %0d", k, order[k], k % 4);
            end
        end
    endtask

    task automatic test_timeout();
        int hi = 0;
        bit fell = 0;
        bit regrant = 0;
        prio = 1'b0; done = 1'b0; req = 4'b0000;
        do_reset();
        req = 4'b0100;
        for (int i = 0; i < 60 && !regrant; i++) begin
            step();
            total++;
            if (io_out !== exp_out()) begin
                bad++;
                $display("FAIL to_model: got %h want %h", io_out, exp_out());
            end
            if (io_out[3:0] == 4'b0100) begin
                if (fell) regrant = 1;
                else hi++;
            end else if (hi > 0 && !fell) begin
                fell = 1;
                total++;
                if (io_out[7] !== 1'b1) begin
                    bad++;
                    $display("FAIL to_pulse: got %b want 1", io_out[7]);
                end
            end
        end
        total++;
        if (hi != TO) begin
            bad++;
            $display("FAIL to_hold: got %0d want %0d", hi, TO);
        end
        total++;
        if (!regrant) begin
            bad++;
            $display("FAIL to_regrant: got 0 want 1");
        end
    endtask

    task automatic test_fixed_prio();
        int grants = 0;
        bit prevv = 0;
        done = 1'b0; req = 4'b0000;
        do_reset();
        prio = 1'b1; req = 4'b1010;
        for (int i = 0; i < 40 && grants < 4; i++) begin
            step();
            total++;
            if (io_out !== exp_out()) begin
                bad++;
                $display("FAIL fp_model: got %h want %h", io_out, exp_out());
            end
            done = 1'b0;
            if (io_out[6] && !prevv) begin
                grants++;
                total++;
                if (io_out[5:4] !== 2'd1) begin
                    bad++;
                    $display("FAIL fp_idx: got %0d want 1", io_out[5:4]);
                end
                done = 1'b1;
            end
            prevv = io_out[6];
        end
        total++;
        if (grants != 4) begin
            bad++;
            $display("FAIL fp_count: got %0d want 4", grants);
        end
        step();
        done = 1'b0; prio = 1'b0; req = 4'b1111;
        step();
        step();
        total++;
        if (io_out !== 8'h64) begin
            bad++;
            $display("FAIL fp_ptr_adv: got %h want 64", io_out);
        end
    endtask

    task automatic test_done_vs_timeout();
        int hi = 0;
        prio = 1'b0; done = 1'b0; req = 4'b0000;
        do_reset();
        req = 4'b0010;
        for (int i = 0; i < 40 && hi < TO; i++) begin
            step();
            if (io_out[3:0] == 4'b0010) hi++;
        end
        total++;
        if (hi != TO) begin
            bad++;
            $display("FAIL dvt_reach: got %0d want %0d", hi, TO);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        total++;
        if (io_out !== 8'h10) begin
            bad++;
            $display("FAIL dvt_release: got %h want 10", io_out);
        end
        step();
        total++;
        if (io_out !== exp_out()) begin
            bad++;
            $display("FAIL dvt_model: got %h want %h", io_out, exp_out());
        end
    endtask

    task automatic test_reset_mid_grant();
        prio = 1'b0; done = 1'b0; req = 4'b0000;
        do_reset();
        req = 4'b0100;
        step();
        total++;
        if (io_out !== 8'h64) begin
            bad++;
            $display("FAIL rmg_grant: got %h want 64", io_out);
        end
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        total++;
        if (io_out !== 8'h00) begin
            bad++;
            $display("FAIL rmg_reset: got %h want 00", io_out);
        end
        rst = 1'b0;
        step();
        total++;
        if (io_out !== 8'h64) begin
            bad++;
            $display("FAIL rmg_regrant: got %h want 64", io_out);
        end
    endtask

    task automatic test_owner_drop();
        logic [7:0] want[5] = '{8'h41, 8'h41, 8'h00, 8'h00, 8'h52};
        logic [3:0] reqs[5] = '{4'b0001, 4'b0011, 4'b0010, 4'b0010, 4'b0010};
        prio = 1'b0; done = 1'b0; req = 4'b0000;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            req = reqs[i];
            step();
            total++;
            if (io_out !== want[i]) begin
                bad++;
                $display("FAIL drop[%0d]: got %h want %h", i, io_out, want[i]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) req = 4'($urandom);
            done = ($urandom_range(7) == 0);
            prio = ($urandom_range(5) == 0);
            rst = ($urandom_range(99) == 0);
            step();
            total++;
            if (io_out !== exp_out()) begin
                bad++;
                $display("FAIL rand_model[%0d]: got %h want %h", i, io_out, exp_out());
            end
            total++;
            if (io_out[6] !== |io_out[3:0] || (io_out[6] && io_out[3:0] !== 4'(1 << io_out[5:4]))) begin
                bad++;
                $display("FAIL rand_onehot[%0d]: got %h want one-hot matching idx", i, io_out);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rr_order();
        test_timeout();
        test_fixed_prio();
        test_done_vs_timeout();
        test_reset_mid_grant();
        test_owner_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
